// File: rtl/wishbone2apb_bridge.sv
// Wishbone slave to APB4 master bridge.
// Takes one Wishbone request at a time and runs a full APB setup/access sequence for it.
// The APB result comes back as a single-cycle Wishbone ack or err.
module wishbone2apb_bridge #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned USE_STALL     = 1,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  output logic                      wb_stall,
  input  logic [ADDRESS_WIDTH-1:0]  wb_adr,
  input  logic                      wb_we,
  input  logic [DATA_WIDTH-1:0]     wb_dat_w,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel,
  output logic                      wb_ack,
  output logic                      wb_err,
  output logic                      wb_rty,
  output logic [DATA_WIDTH-1:0]     wb_dat_r,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic [ADDRESS_WIDTH-1:0]  apb_paddr,
  output logic [2:0]                apb_pprot,
  output logic                      apb_pwrite,
  output logic [DATA_WIDTH-1:0]     apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]   apb_pstrb,
  input  logic                      apb_pready,
  input  logic [DATA_WIDTH-1:0]     apb_prdata,
  input  logic                      apb_pslverr
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when the watchdog is off.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRespond} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            accept;
  logic            timeout_hit;

  assign wb_rty    = 1'b0;
  assign apb_pprot = 3'b000;

  // Stall covers every non-idle state so a pipelined master holds its next request.
  assign wb_stall = (USE_STALL != 0) && (state_q != StIdle);
  assign accept   = wb_cyc && wb_stb && !wb_stall && (state_q == StIdle);

  // Expiry on the last allowed ACCESS cycle; a simultaneous pready takes priority.
  assign timeout_hit = (TIMEOUT != 0) && !apb_pready && (cnt_q == CntW'(TIMEOUT - 1));

  // Bridge FSM with all APB and Wishbone response outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_paddr   <= '0;
      apb_pwrite  <= 1'b0;
      apb_pwdata  <= '0;
      apb_pstrb   <= '0;
      wb_ack      <= 1'b0;
      wb_err      <= 1'b0;
      wb_dat_r    <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wb_dat_r <= '0;
          if (accept) begin
            state_q     <= StSetup;
            apb_psel    <= 1'b1;
            apb_penable <= 1'b0;
            apb_paddr   <= wb_adr;
            apb_pwrite  <= wb_we;
            apb_pwdata  <= wb_dat_w;
            // Reads drive zero strobes.
            apb_pstrb   <= wb_we ? wb_sel : '0;
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          apb_penable <= 1'b1;
          cnt_q       <= '0;
        end
        StAccess: begin
          if (apb_pready) begin
            state_q     <= StRespond;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            cnt_q       <= '0;
            wb_ack      <= !apb_pslverr && wb_cyc;
            wb_err      <= apb_pslverr && wb_cyc;
            wb_dat_r    <= apb_pwrite ? '0 : apb_prdata;
          end else if (timeout_hit) begin
            state_q     <= StRespond;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            cnt_q       <= '0;
            wb_err      <= wb_cyc;
            wb_dat_r    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRespond: begin
          state_q  <= StIdle;
          wb_dat_r <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone2apb_bridge.sv
// Randomised bench for wishbone2apb_bridge against a transaction-timeline model.
module tb_wishbone2apb_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc, wb_stb, wb_stall, wb_we, wb_ack, wb_err, wb_rty;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_w, wb_dat_r;
  logic [SW-1:0] wb_sel;
  logic          apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
  logic [AW-1:0] apb_paddr;
  logic [2:0]    apb_pprot;
  logic [DW-1:0] apb_pwdata, apb_prdata;
  logic [SW-1:0] apb_pstrb;

  wishbone2apb_bridge #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .USE_STALL    (1),
    .TIMEOUT      (TO)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_stall   (wb_stall),
    .wb_adr     (wb_adr),
    .wb_we      (wb_we),
    .wb_dat_w   (wb_dat_w),
    .wb_sel     (wb_sel),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_rty     (wb_rty),
    .wb_dat_r   (wb_dat_r),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_paddr  (apb_paddr),
    .apb_pprot  (apb_pprot),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_pstrb  (apb_pstrb),
    .apb_pready (apb_pready),
    .apb_prdata (apb_prdata),
    .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  // One transaction; waits < 0 means the slave never answers.
  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    int            waits;
    bit            slverr;
    logic [DW-1:0] rdata;
    int            lat;
    bit            ack;
    bit            err;
    logic [DW-1:0] datr;
  } txn_t;

  txn_t dq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;
  bit   rnd_on   = 0;

  // Model: k counts cycles since the accepting edge (k=1 is the setup cycle).
  bit            m_busy;
  int            m_k;
  int            m_acc_len;
  bit            m_to;
  bit            m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_strb;
  logic [DW-1:0] m_rdata;
  bit            m_slverr;
  bit            m_cyc_kept;
  bit            m_is_dir;
  txn_t          m_cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = 0;
    m_k        = 0;
    m_acc_len  = 1;
    m_to       = 0;
    m_is_dir   = 0;
    m_cyc_kept = 1;
  endtask

  task automatic idle_inputs();
    wb_cyc      = 0;
    wb_stb      = 0;
    wb_adr      = '0;
    wb_we       = 0;
    wb_dat_w    = '0;
    wb_sel      = '0;
    apb_pready  = 0;
    apb_prdata  = '0;
    apb_pslverr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"}, 64'(apb_psel), 64'd0);
    chk({tag, "_penable"}, 64'(apb_penable), 64'd0);
    chk({tag, "_ack"}, 64'(wb_ack), 64'd0);
    chk({tag, "_err"}, 64'(wb_err), 64'd0);
    chk({tag, "_stall"}, 64'(wb_stall), 64'd0);
    chk({tag, "_datr"}, 64'(wb_dat_r), 64'd0);
    chk({tag, "_paddr"}, 64'(apb_paddr), 64'd0);
    chk({tag, "_pstrb"}, 64'(apb_pstrb), 64'd0);
  endtask

  // Compare DUT outputs with what the timeline says for the current cycle.
  task automatic check_cycle();
    bit exp_psel, exp_pen, resp, exp_ack, exp_err;
    logic [DW-1:0] exp_datr;
    exp_psel = m_busy && m_k >= 1 && m_k <= 1 + m_acc_len;
    exp_pen  = m_busy && m_k >= 2 && m_k <= 1 + m_acc_len;
    resp     = m_busy && m_k == 2 + m_acc_len;
    exp_ack  = resp && m_cyc_kept && !m_to && !m_slverr;
    exp_err  = resp && m_cyc_kept && (m_to || m_slverr);
    exp_datr = (resp && !m_we && !m_to) ? m_rdata : '0;
    chk("psel", 64'(apb_psel), 64'(exp_psel));
    chk("penable", 64'(apb_penable), 64'(exp_pen));
    chk("stall", 64'(wb_stall), 64'(m_busy));
    chk("ack", 64'(wb_ack), 64'(exp_ack));
    chk("err", 64'(wb_err), 64'(exp_err));
    chk("dat_r", 64'(wb_dat_r), 64'(exp_datr));
    chk("rty", 64'(wb_rty), 64'd0);
    chk("pprot", 64'(apb_pprot), 64'd0);
    if (exp_psel) begin
      chk("paddr", 64'(apb_paddr), 64'(m_adr));
      chk("pwrite", 64'(apb_pwrite), 64'(m_we));
      chk("pwdata", 64'(apb_pwdata), 64'(m_dat));
      chk("pstrb", 64'(apb_pstrb), 64'(m_strb));
    end
    if (resp && m_is_dir) begin
      chk("dir_latency", 64'(m_k), 64'(m_cur.lat));
      chk("dir_ack", 64'(wb_ack), 64'(m_cur.ack));
      chk("dir_err", 64'(wb_err), 64'(m_cur.err));
      chk("dir_datr", 64'(wb_dat_r), 64'(m_cur.datr));
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    t.we     = 1'($urandom_range(0, 1));
    t.adr    = AW'($urandom);
    t.dat    = DW'($urandom);
    t.sel    = SW'($urandom);
    r        = int'($urandom_range(0, 9));
    t.waits  = (r <= 6) ? int'($urandom_range(0, 3)) : (r == 7) ? 7 : (r == 8) ? -1 : 0;
    t.slverr = 0;
    t.rdata  = '0;
    t.lat    = 0;
    t.ack    = 0;
    t.err    = 0;
    t.datr   = '0;
    return t;
  endfunction

  // Drive inputs for the coming edge and advance the model across it.
  task automatic drive_step();
    txn_t e;
    bit   req;
    bit   is_dir;
    int   a;
    bit   in_acc;
    req    = 0;
    is_dir = 0;
    if (!m_busy) begin
      if (dq.size() != 0) begin
        e      = dq.pop_front();
        req    = 1;
        is_dir = 1;
      end else if (rnd_on && $urandom_range(0, 9) < 7) begin
        e   = rand_txn();
        req = 1;
      end
      if (req) begin
        wb_cyc   = 1;
        wb_stb   = 1;
        wb_adr   = e.adr;
        wb_we    = e.we;
        wb_dat_w = e.dat;
        wb_sel   = e.sel;
      end else begin
        wb_cyc   = 1'($urandom_range(0, 1));
        wb_stb   = 0;
        wb_adr   = AW'($urandom);
        wb_we    = 1'($urandom_range(0, 1));
        wb_dat_w = DW'($urandom);
        wb_sel   = SW'($urandom);
      end
      apb_pready  = 1'($urandom_range(0, 1));
      apb_prdata  = DW'($urandom);
      apb_pslverr = 1'($urandom_range(0, 1));
      if (req) begin
        m_busy     = 1;
        m_k        = 1;
        m_we       = e.we;
        m_adr      = e.adr;
        m_dat      = e.dat;
        m_strb     = e.we ? e.sel : '0;
        m_to       = (e.waits < 0);
        m_acc_len  = m_to ? int'(TO) : e.waits + 1;
        m_rdata    = '0;
        m_slverr   = 0;
        m_cyc_kept = 1;
        m_is_dir   = is_dir;
        m_cur      = e;
      end
    end else begin
      // Dropping cyc is only done in the setup cycle and held until idle.
      if (m_k == 1 && !m_is_dir && $urandom_range(0, 7) == 0) m_cyc_kept = 0;
      wb_cyc   = m_cyc_kept;
      wb_stb   = m_cyc_kept ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_adr   = AW'($urandom);
      wb_we    = 1'($urandom_range(0, 1));
      wb_dat_w = DW'($urandom);
      wb_sel   = SW'($urandom);
      a        = m_k - 1;
      in_acc   = (m_k >= 2) && (m_k <= 1 + m_acc_len);
      apb_pready  = in_acc ? (!m_to && a == m_acc_len) : 1'($urandom_range(0, 1));
      apb_prdata  = m_is_dir ? m_cur.rdata : DW'($urandom);
      apb_pslverr = m_is_dir ? m_cur.slverr : ($urandom_range(0, 3) == 0);
      if (in_acc && apb_pready) begin
        m_rdata  = apb_prdata;
        m_slverr = apb_pslverr;
      end
      m_k++;
      if (m_k > 2 + m_acc_len) m_busy = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc_n++;
    check_cycle();
    drive_step();
  endtask

  function automatic txn_t mk(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic [SW-1:0] sel, input int waits, input bit slverr,
                              input logic [DW-1:0] rdata, input int lat, input bit ack,
                              input bit err, input logic [DW-1:0] datr);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.waits = waits; t.slverr = slverr;
    t.rdata = rdata; t.lat = lat; t.ack = ack; t.err = err; t.datr = datr;
    return t;
  endfunction

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((dq.size() != 0 || m_busy) && n < budget) begin
      cycle();
      n++;
    end
    if (dq.size() != 0 || m_busy) begin
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    bit found;
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    dq.push_back(mk(1, 16'h0010, 32'hA5A5_1234, 4'b0011, 0, 0, 32'h0, 3, 1, 0, 32'h0));
    dq.push_back(mk(0, 16'h0020, 32'h1111_2222, 4'b1111, 2, 0, 32'hDEAD_BEEF, 5, 1, 0,
                    32'hDEAD_BEEF));
    dq.push_back(mk(0, 16'h0030, 32'h0, 4'b1111, 1, 1, 32'h1234_5678, 4, 0, 1, 32'h1234_5678));
    dq.push_back(mk(0, 16'h0040, 32'h0, 4'b0101, 0, 0, 32'hCAFE_0001, 3, 1, 0, 32'hCAFE_0001));
    dq.push_back(mk(1, 16'h0100, 32'h0000_0001, 4'b1111, 0, 0, 32'h0, 3, 1, 0, 32'h0));
    dq.push_back(mk(1, 16'h0104, 32'h0000_0002, 4'b1100, 1, 0, 32'h0, 4, 1, 0, 32'h0));
    dq.push_back(mk(1, 16'h0108, 32'h0000_0003, 4'b0001, 0, 0, 32'h0, 3, 1, 0, 32'h0));
    dq.push_back(mk(0, 16'h0200, 32'h0, 4'b1111, -1, 0, 32'h5555_AAAA, 10, 0, 1, 32'h0));
    dq.push_back(mk(1, 16'h0300, 32'h7777_8888, 4'b1010, 7, 0, 32'h0, 10, 1, 0, 32'h0));
    run_until_done("directed", 200);

    rnd_on = 1;
    repeat (3000) cycle();
    rnd_on = 0;
    run_until_done("drain", 40);

    // Reset while a read sits in an access wait state.
    dq.push_back(mk(0, 16'h0050, 32'h0, 4'b1111, 3, 0, 32'h9999_0000, 6, 1, 0, 32'h9999_0000));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      cyc_n++;
      check_cycle();
      if (m_busy && m_k == 3) found = 1;
      else drive_step();
    end
    if (!found) begin
      failures++;
      $display("FAIL reach_access actual=not_reached required=access within 20 cycles");
    end
    rst_n = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    dq.push_back(mk(1, 16'h0060, 32'h0BAD_F00D, 4'b1111, 0, 0, 32'h0, 3, 1, 0, 32'h0));
    run_until_done("post_reset", 20);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
